// File: rtl/display_pkg.sv
// Shared definitions for the LED-matrix display path: coordinate width,
// colour type, SPI command word layout and fill engine states.
package display_pkg;

    localparam int COORD_W    = 6;
    localparam int WORD_W     = 16;
    localparam int BIT_CNT_W  = 4;
    // One extra bit marks "sweep finished" after the last pixel index.
    localparam int FILL_CNT_W = 2 * COORD_W + 1;

    typedef logic [2:0] color_t;

    // Opcode lives in the MSB of every command word.
    localparam logic CMD_PIXEL = 1'b0;
    localparam logic CMD_FILL  = 1'b1;

    // Command word field positions.
    localparam int OP_BIT         = 15;
    localparam int PIX_COLOR_MSB  = 14;
    localparam int PIX_COLOR_LSB  = 12;
    localparam int PIX_X_MSB      = 11;
    localparam int PIX_X_LSB      = 6;
    localparam int PIX_Y_MSB      = 5;
    localparam int PIX_Y_LSB      = 0;
    localparam int FILL_COLOR_MSB = 2;
    localparam int FILL_COLOR_LSB = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        FILLING = 1'b1
    } fill_state_t;

endpackage

// File: rtl/spi_sync.sv
// Synchronizer chain for one asynchronous bit plus registered rise/fall
// detect. The chain itself is not reset so that a level already high at
// reset release never looks like a fresh edge.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              hist_q, hist_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Next-state: shift the chain, remember the last synchronized level, flag edges.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_i};
        hist_d  = chain_q[STAGES-1];
        rise_d  = chain_q[STAGES-1] & ~hist_q;
        fall_d  = ~chain_q[STAGES-1] & hist_q;
    end

    // Synchronizer and history flops run freely.
    always_ff @(posedge clk_in) begin
        chain_q <= chain_d;
        hist_q  <= hist_d;
    end

    // Edge flags are cleared by reset so nothing fires during abort.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI (mode 0, MSB first) command receiver driving the display's
// single-pixel write port, with a one-entry pending pixel and a
// full-screen fill engine that takes priority over pixel writes.
module spi_pixel_rx
    import display_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               sclk,
    input  logic               sdi,
    input  logic               ce,
    output logic               sdo,
    output logic               write_en,
    output logic [COORD_W-1:0] write_x,
    output logic [COORD_W-1:0] write_y,
    output color_t             write_color,
    output logic               fill_busy,
    output logic               overflow
);

    // ---------------- input synchronization ----------------
    logic sclk_sync, sclk_rise, sclk_fall;
    logic ce_sync, ce_rise, ce_fall;
    logic unused_edges;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .async_i(sclk),
        .sync_o (sclk_sync),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_ce_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .async_i(ce),
        .sync_o (ce_sync),
        .rise_o (ce_rise),
        .fall_o (ce_fall)
    );

    assign unused_edges = sclk_sync ^ sclk_fall ^ ce_fall;

    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sdi_bit;

    // Data line only needs the plain synchronizer chain.
    always_comb begin
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    end

    // Free-running data synchronizer.
    always_ff @(posedge clk_in) begin
        sdi_sync_q <= sdi_sync_d;
    end

    assign sdi_bit = sdi_sync_q[SYNC_STAGES-1];

    // ---------------- word assembly ----------------
    // armed is set only by a ce rise, so after reset a new frame is needed.
    logic                 armed_q, armed_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]    shift_q, shift_d;
    logic                 word_valid_q, word_valid_d;
    logic [WORD_W-1:0]    word_q, word_d;

    // Shift in one bit per sclk rise inside an armed frame; drop partials on ce low/rise.
    always_comb begin
        armed_d      = armed_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (!ce_sync) begin
            armed_d   = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (ce_rise) begin
            armed_d   = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (armed_q && sclk_rise) begin
            shift_d = {shift_q[WORD_W-2:0], sdi_bit};
            if (bit_cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
                word_valid_d = 1'b1;
                word_d       = shift_d;
                bit_cnt_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
        end
    end

    // Receiver registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            armed_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    // ---------------- decode, fill engine, arbitration ----------------
    logic               new_pix, new_fill;
    logic [COORD_W-1:0] pix_x, pix_y;
    color_t             pix_color, cmd_fill_color;

    assign new_pix        = word_valid_q && (word_q[OP_BIT] == CMD_PIXEL);
    assign new_fill       = word_valid_q && (word_q[OP_BIT] == CMD_FILL);
    assign pix_x          = word_q[PIX_X_MSB:PIX_X_LSB];
    assign pix_y          = word_q[PIX_Y_MSB:PIX_Y_LSB];
    assign pix_color      = word_q[PIX_COLOR_MSB:PIX_COLOR_LSB];
    assign cmd_fill_color = word_q[FILL_COLOR_MSB:FILL_COLOR_LSB];

    fill_state_t           state_q, state_d;
    logic [FILL_CNT_W-1:0] idx_q, idx_d;        // index of the next fill write
    color_t                fill_color_q, fill_color_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [COORD_W-1:0]    pend_x_q, pend_x_d;
    logic [COORD_W-1:0]    pend_y_q, pend_y_d;
    color_t                pend_color_q, pend_color_d;
    logic                  overflow_q, overflow_d;
    logic                  write_en_q, write_en_d;
    logic [COORD_W-1:0]    write_x_q, write_x_d;
    logic [COORD_W-1:0]    write_y_q, write_y_d;
    color_t                write_color_q, write_color_d;
    logic                  sdo_q, sdo_d;

    // Fill FSM next state and write arbitration: fill > pending > new pixel.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fill_color_d  = fill_color_q;
        pend_valid_d  = pend_valid_q;
        pend_x_d      = pend_x_q;
        pend_y_d      = pend_y_q;
        pend_color_d  = pend_color_q;
        overflow_d    = overflow_q;
        write_en_d    = 1'b0;
        write_x_d     = write_x_q;
        write_y_d     = write_y_q;
        write_color_d = write_color_q;
        sdo_d         = (state_q == FILLING);

        if (new_fill) begin
            // Start or restart the sweep; pixel (0,0) is written right away.
            state_d       = FILLING;
            fill_color_d  = cmd_fill_color;
            idx_d         = FILL_CNT_W'(1);
            write_en_d    = 1'b1;
            write_x_d     = '0;
            write_y_d     = '0;
            write_color_d = cmd_fill_color;
        end else if ((state_q == FILLING) && !idx_q[FILL_CNT_W-1]) begin
            write_en_d    = 1'b1;
            write_x_d     = idx_q[COORD_W-1:0];
            write_y_d     = idx_q[2*COORD_W-1:COORD_W];
            write_color_d = fill_color_q;
            idx_d         = idx_q + FILL_CNT_W'(1);
            if (new_pix) begin
                if (pend_valid_q) begin
                    overflow_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_x_d     = pix_x;
                    pend_y_d     = pix_y;
                    pend_color_d = pix_color;
                end
            end
        end else begin
            // Idle, or the sweep just finished: pending pixel goes first.
            state_d = IDLE;
            idx_d   = '0;
            if (pend_valid_q) begin
                write_en_d    = 1'b1;
                write_x_d     = pend_x_q;
                write_y_d     = pend_y_q;
                write_color_d = pend_color_q;
                if (new_pix) begin
                    pend_x_d     = pix_x;
                    pend_y_d     = pix_y;
                    pend_color_d = pix_color;
                end else begin
                    pend_valid_d = 1'b0;
                end
            end else if (new_pix) begin
                write_en_d    = 1'b1;
                write_x_d     = pix_x;
                write_y_d     = pix_y;
                write_color_d = pix_color;
            end
        end
    end

    // Fill engine, pending entry and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            fill_color_q  <= '0;
            pend_valid_q  <= 1'b0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            pend_color_q  <= '0;
            overflow_q    <= 1'b0;
            write_en_q    <= 1'b0;
            write_x_q     <= '0;
            write_y_q     <= '0;
            write_color_q <= '0;
            sdo_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fill_color_q  <= fill_color_d;
            pend_valid_q  <= pend_valid_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            pend_color_q  <= pend_color_d;
            overflow_q    <= overflow_d;
            write_en_q    <= write_en_d;
            write_x_q     <= write_x_d;
            write_y_q     <= write_y_d;
            write_color_q <= write_color_d;
            sdo_q         <= sdo_d;
        end
    end

    assign fill_busy   = (state_q == FILLING);
    assign sdo         = sdo_q;
    assign overflow    = overflow_q;
    assign write_en    = write_en_q;
    assign write_x     = write_x_q;
    assign write_y     = write_y_q;
    assign write_color = write_color_q;

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Bench for spi_pixel_rx: SPI frame driver, write scoreboard with an
// expected queue of {color,x,y}, fill_busy run-length and sdo checks.
module tb_spi_pixel_rx;

    logic       clk_in;
    logic       reset;
    logic       sclk;
    logic       sdi;
    logic       ce;
    logic       sdo;
    logic       write_en;
    logic [5:0] write_x;
    logic [5:0] write_y;
    logic [2:0] write_color;
    logic       fill_busy;
    logic       overflow;

    spi_pixel_rx #(.SYNC_STAGES(2)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .sclk       (sclk),
        .sdi        (sdi),
        .ce         (ce),
        .sdo        (sdo),
        .write_en   (write_en),
        .write_x    (write_x),
        .write_y    (write_y),
        .write_color(write_color),
        .fill_busy  (fill_busy),
        .overflow   (overflow)
    );

    // ---------------- clock / reset ----------------
    int   cyc = 0;
    logic rst_at_edge = 1'b1;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // ---------------- scoreboard state ----------------
    logic [14:0] exp_q[$];        // {color, x, y}
    int          exp_busy_q[$];   // expected fill_busy run lengths
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_en = 1'b0;
    logic        prev_busy = 1'b0;
    int          busy_run = 0;
    int          busy_rise_cyc = -1;
    int          last_busy_wr_cyc = -1;
    int          last_idle_wr_cyc = -1;
    int          last_rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [14:0] fill_entry(input logic [2:0] color, input int idx);
        logic [11:0] i12;
        i12 = idx[11:0];
        return {color, i12[5:0], i12[11:6]};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (write_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    if (n_fail <= 30)
                        $display("FAIL unexpected_write: got c=%0d x=%0d y=%0d, expected none (cycle %0d)",
                                 write_color, write_x, write_y, cyc);
                end else begin
                    check("write", {17'd0, write_color, write_x, write_y}, {17'd0, exp_q.pop_front()});
                end
                if (fill_busy) last_busy_wr_cyc = cyc;
                else           last_idle_wr_cyc = cyc;
            end
            check("sdo", {31'd0, sdo}, {31'd0, (rst_at_edge ? 1'b0 : prev_busy)});
            if (fill_busy) begin
                if (!prev_busy) busy_rise_cyc = cyc;
                busy_run++;
            end else if (busy_run > 0) begin
                if (exp_busy_q.size() == 0) check("busy_run_unexpected", busy_run, 0);
                else                        check("busy_run", busy_run, exp_busy_q.pop_front());
                busy_run = 0;
            end
            prev_busy = fill_busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic frame_begin();
        @(negedge clk_in);
        ce = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic frame_end();
        ce = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    // Each bit takes 8 clocks: data set with sclk low, sclk high after 4.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            sdi = w[i];
            repeat (4) @(negedge clk_in);
            sclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (4) @(negedge clk_in);
            sclk = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        frame_begin();
        send_bits(w, 16);
        frame_end();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fill_busy) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #(10 * 40000);
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : main
        int r;
        reset = 1'b1;
        ce    = 1'b0;
        sclk  = 1'b0;
        sdi   = 1'b0;
        repeat (6) @(negedge clk_in);
        check("rst_write_en", {31'd0, write_en}, 0);
        check("rst_write_x", {26'd0, write_x}, 0);
        check("rst_write_y", {26'd0, write_y}, 0);
        check("rst_write_color", {29'd0, write_color}, 0);
        check("rst_fill_busy", {31'd0, fill_busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_sdo", {31'd0, sdo}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk_in);
        mon_en = 1'b1;

        // Single pixel 0x2C5A: color 010, x=49, y=26, write 4 cycles after capture.
        exp_q.push_back({3'b010, 6'd49, 6'd26});
        send_word(16'h2C5A);
        wait_drain("pixel", 100);
        check("pixel_latency", last_idle_wr_cyc, last_rise_cyc + 5);

        // Partial word (9 bits) aborted by ce drop, then pixel 0x0000.
        exp_q.push_back({3'b000, 6'd0, 6'd0});
        frame_begin();
        send_bits(16'hFFFF, 9);
        frame_end();
        send_word(16'h0000);
        wait_drain("partial", 200);
        check("partial_latency", last_idle_wr_cyc, last_rise_cyc + 5);
        check("overflow_clear", {31'd0, overflow}, 0);

        // Fill 0x8006 with pixel 0x1041 pending and 0x7FFF dropped.
        for (int i = 0; i < 4096; i++) exp_q.push_back(fill_entry(3'b110, i));
        exp_q.push_back({3'b001, 6'd1, 6'd1});
        exp_busy_q.push_back(4096);
        send_word(16'h8006);
        r = last_rise_cyc;
        send_word(16'h1041);
        check("no_overflow_yet", {31'd0, overflow}, 0);
        send_word(16'h7FFF);
        check("busy_start", busy_rise_cyc, r + 5);
        wait_drain("fill_pending", 5000);
        check("overflow_set", {31'd0, overflow}, 1);
        check("pending_after_fill", last_idle_wr_cyc, last_busy_wr_cyc + 1);

        // Fill 0x8001 restarted by 0x8004 sent back-to-back in the same frame:
        // 128 clocks per word means 128 writes of the first colour before restart.
        for (int i = 0; i < 128; i++) exp_q.push_back(fill_entry(3'b001, i));
        for (int i = 0; i < 4096; i++) exp_q.push_back(fill_entry(3'b100, i));
        exp_busy_q.push_back(128 + 4096);
        frame_begin();
        send_bits(16'h8001, 16);
        send_bits(16'h8004, 16);
        frame_end();
        wait_drain("fill_restart", 5000);
        check("overflow_sticky", {31'd0, overflow}, 1);

        // Reset one cycle mid-fill after 100 writes of colour 111.
        for (int i = 0; i < 100; i++) exp_q.push_back(fill_entry(3'b111, i));
        exp_busy_q.push_back(100);
        send_word(16'h8007);
        r = last_rise_cyc;
        while (cyc < r + 104) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check("midrst_write_en", {31'd0, write_en}, 0);
        check("midrst_write_x", {26'd0, write_x}, 0);
        check("midrst_write_y", {26'd0, write_y}, 0);
        check("midrst_write_color", {29'd0, write_color}, 0);
        check("midrst_fill_busy", {31'd0, fill_busy}, 0);
        check("midrst_overflow", {31'd0, overflow}, 0);
        check("midrst_sdo", {31'd0, sdo}, 0);
        reset = 1'b0;
        repeat (200) @(negedge clk_in);
        check("midrst_no_writes", exp_q.size(), 0);

        // Fresh frame after reset is accepted again.
        exp_q.push_back({3'b001, 6'd1, 6'd1});
        send_word(16'h1041);
        wait_drain("post_reset", 200);
        check("busy_runs_seen", exp_busy_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
